// File: rtl/host_mem_bridge.sv
// host_mem_bridge: host-side sequencer for the processor array's external memory port.
// Streams a load image in, lets the cores run until they all finish, then streams a result window out.
`default_nettype none

module host_mem_bridge #(
  parameter int RUN_GUARD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] load_base,
  input  logic [15:0] load_count,
  input  logic [15:0] read_base,
  input  logic [15:0] read_count,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [1:0]  status,
  output logic [15:0] com_addr,
  output logic [15:0] com_data_in,
  output logic        com_wr_en,
  input  logic [15:0] com_data_out,
  input  logic        end_process,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] run_cycles
);

  localparam logic [1:0] ST_LOAD = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_READ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FLUSH, S_RUN, S_READ_ADDR, S_READ_WAIT, S_READ_OUT, S_DONE
  } state_t;

  state_t      state, state_n;
  logic [15:0] lbase, lcount, rbase, rcount;
  logic [15:0] lbase_n, lcount_n, rbase_n, rcount_n;
  logic [15:0] idx, idx_n, ridx, ridx_n;
  logic [1:0]  status_n;
  logic [15:0] addr_n, wdata_n, odata_n;
  logic        wr_n, ovalid_n, done_n;
  logic [31:0] cycles_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      lbase       <= '0;
      lcount      <= '0;
      rbase       <= '0;
      rcount      <= '0;
      idx         <= '0;
      ridx        <= '0;
      status      <= ST_LOAD;
      com_addr    <= '0;
      com_data_in <= '0;
      com_wr_en   <= 1'b0;
      in_ready    <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      run_cycles  <= '0;
    end else begin
      state       <= state_n;
      lbase       <= lbase_n;
      lcount      <= lcount_n;
      rbase       <= rbase_n;
      rcount      <= rcount_n;
      idx         <= idx_n;
      ridx        <= ridx_n;
      status      <= status_n;
      com_addr    <= addr_n;
      com_data_in <= wdata_n;
      com_wr_en   <= wr_n;
      in_ready    <= (state_n == S_LOAD);
      out_data    <= odata_n;
      out_valid   <= ovalid_n;
      busy        <= (state_n != S_IDLE);
      done        <= done_n;
      run_cycles  <= cycles_n;
    end
  end

  // Every output is computed one cycle ahead so that all of them leave the block registered.
  always_comb begin
    state_n  = state;
    lbase_n  = lbase;
    lcount_n = lcount;
    rbase_n  = rbase;
    rcount_n = rcount;
    idx_n    = idx;
    ridx_n   = ridx;
    status_n = status;
    addr_n   = com_addr;
    wdata_n  = com_data_in;
    wr_n     = 1'b0;
    odata_n  = out_data;
    ovalid_n = out_valid;
    done_n   = 1'b0;
    cycles_n = run_cycles;

    case (state)
      S_IDLE: begin
        status_n = ST_LOAD;
        if (start) begin
          lbase_n  = load_base;
          lcount_n = load_count;
          rbase_n  = read_base;
          rcount_n = read_count;
          idx_n    = '0;
          ridx_n   = '0;
          cycles_n = '0;
          if (load_count == 16'd0) begin
            state_n  = S_RUN;
            status_n = ST_RUN;
          end else begin
            state_n = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready) begin
          wr_n    = 1'b1;
          addr_n  = lbase + idx;
          wdata_n = in_data;
          idx_n   = idx + 16'd1;
          if (idx == lcount - 16'd1) state_n = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_n  = S_RUN;
        status_n = ST_RUN;
      end
      S_RUN: begin
        if (run_cycles != 32'hFFFF_FFFF) cycles_n = run_cycles + 32'd1;
        // run_cycles equals the number of RUN cycles already completed, so it doubles as the guard count.
        if (end_process && (run_cycles >= 32'(RUN_GUARD))) begin
          if (rcount == 16'd0) begin
            state_n  = S_DONE;
            status_n = ST_LOAD;
            done_n   = 1'b1;
          end else begin
            state_n  = S_READ_ADDR;
            status_n = ST_READ;
            addr_n   = rbase + ridx;
          end
        end
      end
      S_READ_ADDR: state_n = S_READ_WAIT;
      S_READ_WAIT: begin
        state_n  = S_READ_OUT;
        odata_n  = com_data_out;
        ovalid_n = 1'b1;
      end
      S_READ_OUT: begin
        if (out_ready) begin
          ovalid_n = 1'b0;
          ridx_n   = ridx + 16'd1;
          if (ridx == rcount - 16'd1) begin
            state_n  = S_DONE;
            status_n = ST_LOAD;
            done_n   = 1'b1;
          end else begin
            state_n = S_READ_ADDR;
            addr_n  = rbase + ridx + 16'd1;
          end
        end
      end
      S_DONE: begin
        state_n  = S_IDLE;
        status_n = ST_LOAD;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_host_mem_bridge.sv
// Directed self-checking bench for host_mem_bridge with a behavioural data memory on the com port.
`default_nettype none

module tb_host_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] load_base = '0, load_count = '0, read_base = '0, read_count = '0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  status;
  logic [15:0] com_addr, com_data_in, com_data_out;
  logic        com_wr_en;
  logic        end_process = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy, done;
  logic [31:0] run_cycles;

  int total = 0;
  int bad = 0;
  int wr_outside = 0;
  logic [15:0] mem [0:65535];

  host_mem_bridge #(.RUN_GUARD(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .load_base(load_base), .load_count(load_count),
    .read_base(read_base), .read_count(read_count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .status(status), .com_addr(com_addr), .com_data_in(com_data_in),
    .com_wr_en(com_wr_en), .com_data_out(com_data_out),
    .end_process(end_process),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  // Memory model: writes on strobe, read data one cycle after the address.
  always @(posedge clk) begin
    if (com_wr_en) mem[com_addr] <= com_data_in;
    com_data_out <= mem[com_addr];
  end

  always @(negedge clk) begin
    if (com_wr_en && status !== 2'b00) wr_outside++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] lb, input logic [15:0] lc,
                           input logic [15:0] rb, input logic [15:0] rc);
    load_base = lb; load_count = lc; read_base = rb; read_count = rc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({status, com_wr_en, in_ready, out_valid, busy, done} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000000", {status, com_wr_en, in_ready, out_valid, busy, done});
    end
    total++;
    if ({com_addr, com_data_in, out_data} !== 48'h0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {com_addr, com_data_in, out_data});
    end
    total++;
    if (run_cycles !== 32'd0) begin bad++; $display("FAIL reset_run_cycles: got %0d want 0", run_cycles); end
  endtask

  task automatic test_load_run_read;
    logic [15:0] words [4];
    words[0] = 16'h00A1; words[1] = 16'h00B2; words[2] = 16'h00C3; words[3] = 16'h00D4;
    start_job(16'h0010, 16'd4, 16'h0011, 16'd2);
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      bad++; $display("FAIL lrr_start: busy=%b in_ready=%b want 1 1", busy, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = words[i];
      tick();
      total++;
      if (com_wr_en !== 1'b1 || com_addr !== 16'h0010 + 16'(i) || com_data_in !== words[i]) begin
        bad++; $display("FAIL lrr_write%0d: en=%b addr=%h data=%h want 1 %h %h", i, com_wr_en, com_addr,
                        com_data_in, 16'h0010 + 16'(i), words[i]);
      end
    end
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0 || status !== 2'b00) begin
      bad++; $display("FAIL lrr_flush: in_ready=%b status=%b want 0 00", in_ready, status);
    end
    tick();
    total++;
    if (status !== 2'b01 || com_wr_en !== 1'b0) begin
      bad++; $display("FAIL lrr_run: status=%b wr_en=%b want 01 0", status, com_wr_en);
    end
    repeat (9) tick();
    end_process = 1'b1;
    tick();
    end_process = 1'b0;
    total++;
    if (status !== 2'b10 || com_addr !== 16'h0011 || run_cycles !== 32'd10) begin
      bad++; $display("FAIL lrr_read_addr: status=%b addr=%h cycles=%0d want 10 0011 10", status, com_addr, run_cycles);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL lrr_wait: out_valid=%b want 0", out_valid); end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h00B2) begin
      bad++; $display("FAIL lrr_out0: valid=%b data=%h want 1 00B2", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || status !== 2'b10 || com_addr !== 16'h0012) begin
      bad++; $display("FAIL lrr_addr1: valid=%b status=%b addr=%h want 0 10 0012", out_valid, status, com_addr);
    end
    tick(); tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h00C3) begin
      bad++; $display("FAIL lrr_out1: valid=%b data=%h want 1 00C3", out_valid, out_data);
    end
    tick();
    out_ready = 1'b0;
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || status !== 2'b00) begin
      bad++; $display("FAIL lrr_done: done=%b busy=%b valid=%b status=%b want 1 1 0 00", done, busy, out_valid, status);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL lrr_idle: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure;
    int n;
    start_job(16'h0040, 16'd2, 16'h0040, 16'd1);
    in_valid = 1'b1; in_data = 16'h1111;
    tick();
    total++;
    if (com_wr_en !== 1'b1 || com_addr !== 16'h0040) begin
      bad++; $display("FAIL bp_w0: en=%b addr=%h want 1 0040", com_wr_en, com_addr);
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (com_wr_en !== 1'b0) begin bad++; $display("FAIL bp_gap: en=%b want 0", com_wr_en); end
    in_valid = 1'b1; in_data = 16'h2222;
    tick();
    in_valid = 1'b0;
    total++;
    if (com_wr_en !== 1'b1 || com_addr !== 16'h0041 || com_data_in !== 16'h2222 || in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_w1: en=%b addr=%h data=%h rdy=%b want 1 0041 2222 0", com_wr_en, com_addr,
                      com_data_in, in_ready);
    end
    end_process = 1'b1;
    for (n = 0; n < 50 && out_valid !== 1'b1; n++) tick();
    end_process = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_timeout: out_valid=%b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'h1111) begin
        bad++; $display("FAIL bp_hold%0d: valid=%b data=%h want 1 1111", i, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_done: done=%b valid=%b want 1 0", done, out_valid);
    end
    tick();
  endtask

  task automatic test_wrap;
    int n;
    logic [15:0] addrs [3];
    addrs[0] = 16'hFFFE; addrs[1] = 16'hFFFF; addrs[2] = 16'h0000;
    start_job(16'hFFFE, 16'd3, 16'h0000, 16'd0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'h0A0A + 16'(i);
      tick();
      total++;
      if (com_wr_en !== 1'b1 || com_addr !== addrs[i] || com_data_in !== 16'h0A0A + 16'(i)) begin
        bad++; $display("FAIL wrap_w%0d: en=%b addr=%h data=%h want 1 %h %h", i, com_wr_en, com_addr,
                        com_data_in, addrs[i], 16'h0A0A + 16'(i));
      end
    end
    in_valid = 1'b0;
    end_process = 1'b1;
    for (n = 0; n < 50 && done !== 1'b1; n++) tick();
    end_process = 1'b0;
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL wrap_timeout: done=%b want 1", done); end
    tick();
  endtask

  task automatic test_guard_zero_counts;
    end_process = 1'b1;
    start_job(16'h0000, 16'd0, 16'h0000, 16'd0);
    total++;
    if (status !== 2'b01 || busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL zero_load: status=%b busy=%b rdy=%b want 01 1 0", status, busy, in_ready);
    end
    tick();
    total++;
    if (status !== 2'b01 || done !== 1'b0) begin
      bad++; $display("FAIL guard1: status=%b done=%b want 01 0", status, done);
    end
    tick();
    total++;
    if (status !== 2'b01 || done !== 1'b0) begin
      bad++; $display("FAIL guard2: status=%b done=%b want 01 0", status, done);
    end
    tick();
    end_process = 1'b0;
    total++;
    if (done !== 1'b1 || run_cycles !== 32'd3 || out_valid !== 1'b0 || status !== 2'b00) begin
      bad++; $display("FAIL zero_read: done=%b cycles=%0d valid=%b status=%b want 1 3 0 00", done, run_cycles,
                      out_valid, status);
    end
    tick();
  endtask

  task automatic test_reset_mid_load;
    int n;
    start_job(16'h0080, 16'd4, 16'h0090, 16'd1);
    in_valid = 1'b1; in_data = 16'h5550;
    tick();
    in_data = 16'h5551;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    total++;
    if (com_wr_en !== 1'b0 || status !== 2'b00 || busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL mid_rst: en=%b status=%b busy=%b rdy=%b want 0 00 0 0", com_wr_en, status, busy, in_ready);
    end
    start_job(16'h0090, 16'd1, 16'h0090, 16'd1);
    in_valid = 1'b1; in_data = 16'h7777;
    tick();
    in_valid = 1'b0;
    total++;
    if (com_wr_en !== 1'b1 || com_addr !== 16'h0090 || com_data_in !== 16'h7777) begin
      bad++; $display("FAIL restart_w0: en=%b addr=%h data=%h want 1 0090 7777", com_wr_en, com_addr, com_data_in);
    end
    end_process = 1'b1;
    for (n = 0; n < 50 && out_valid !== 1'b1; n++) tick();
    end_process = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h7777) begin
      bad++; $display("FAIL restart_out: valid=%b data=%h want 1 7777", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL restart_done: done=%b want 1", done); end
    tick();
    total++;
    if (wr_outside !== 0) begin
      bad++; $display("FAIL wr_outside_load: got %0d want 0", wr_outside);
    end
  endtask

  initial begin
    test_reset();
    test_load_run_read();
    test_backpressure();
    test_wrap();
    test_guard_zero_counts();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
